// File: rtl/cp0_write_sequencer_pkg.sv
// Shared definitions for the CP0 write sequencer: register numbers,
// exception codes, Status/Cause bit positions and the sequencer state encoding.
package cp0_write_sequencer_pkg;

  localparam int CP0_ADDR_BUS = 8;

  // CP0 register numbers; the port address is {regnum, 3'b000}
  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam int STATUS_EXL_BIT = 1;
  localparam int CAUSE_BD_BIT   = 31;

  localparam logic [31:0] STATUS_EXL_MASK = 32'h0000_0002;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_EPC    = 3'd1,
    W_CAUSE  = 3'd2,
    W_STATUS = 3'd3,
    W_BADV   = 3'd4,
    W_ERET   = 3'd5
  } seq_state_t;

  function automatic logic [CP0_ADDR_BUS-1:0] cp0_addr(input logic [4:0] regnum);
    return {regnum, 3'b000};
  endfunction

  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_wb_write_buffer.sv
// One-entry holding register for MTC0 writes that cannot use the CP0 port
// right away. A push while full overwrites, so the latest write wins.
// A push in the same cycle as a pop refills the entry.
module cp0_wb_write_buffer
  import cp0_write_sequencer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [CP0_ADDR_BUS-1:0] push_addr,
  input  logic [31:0]             push_data,
  input  logic                    pop,
  output logic                    buf_valid,
  output logic [CP0_ADDR_BUS-1:0] buf_addr,
  output logic [31:0]             buf_data
);

  // Hold the most recent deferred write until the sequencer drains it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if (push) begin
      buf_valid <= 1'b1;
      buf_addr  <= push_addr;
      buf_data  <= push_data;
    end else if (pop) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cp0_write_sequencer.sv
// CP0 single-write-port sequencer: serialises exception/ERET commits and
// arbitrates them against MTC0 writes from WB.
// Optional feature macro: CP0_BADVADDR_EN (adds the BadVAddr write step for
// address-error exceptions).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | port carries buffered or pass-through WB write
// W_EPC    | write EPC (skipped when Status.EXL already set)
// W_CAUSE  | write Cause with BD flag and ExcCode merged in
// W_STATUS | write Status with EXL set; redirect unless BadVAddr follows
// W_BADV   | write BadVAddr and redirect (CP0_BADVADDR_EN only)
// W_ERET   | write Status with EXL cleared and redirect to EPC
module cp0_write_sequencer
  import cp0_write_sequencer_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wb_cp0_write_en,
  input  logic [CP0_ADDR_BUS-1:0] wb_cp0_write_addr,
  input  logic [31:0]             wb_cp0_write_data,
  input  logic                    exc_req,
  input  logic [4:0]              exc_code,
  input  logic [31:0]             exc_pc,
  input  logic                    exc_in_delay_slot,
  input  logic [31:0]             exc_badvaddr,
  input  logic                    eret_req,
  input  logic [31:0]             status_i,
  input  logic [31:0]             cause_i,
  input  logic [31:0]             epc_i,
  output logic                    cp0_write_en,
  output logic [CP0_ADDR_BUS-1:0] cp0_write_addr,
  output logic [31:0]             cp0_write_data,
  output logic                    busy_o,
  output logic                    redirect_o,
  output logic [31:0]             redirect_pc_o
);

  seq_state_t state_q, state_d;

  logic [4:0]  code_q;
  logic [31:0] pc_q;
  logic        bd_q;

  logic                    idle;
  logic                    take_exc;
  logic                    buf_push;
  logic                    buf_pop;
  logic                    buf_valid;
  logic [CP0_ADDR_BUS-1:0] buf_addr;
  logic [31:0]             buf_data;

  assign idle     = (state_q == IDLE);
  assign take_exc = idle & exc_req;
  assign busy_o   = ~idle;

  // In IDLE the buffer owns the port, so a simultaneous WB write must wait
  assign buf_push = wb_cp0_write_en & (~idle | buf_valid);
  assign buf_pop  = idle & buf_valid;

  cp0_wb_write_buffer u_wb_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (buf_push),
    .push_addr (wb_cp0_write_addr),
    .push_data (wb_cp0_write_data),
    .pop       (buf_pop),
    .buf_valid (buf_valid),
    .buf_addr  (buf_addr),
    .buf_data  (buf_data)
  );

  // Capture exception context when the sequence starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= '0;
      pc_q   <= '0;
      bd_q   <= 1'b0;
    end else if (take_exc) begin
      code_q <= exc_code;
      pc_q   <= exc_pc;
      bd_q   <= exc_in_delay_slot;
    end
  end

`ifdef CP0_BADVADDR_EN
  logic [31:0] badv_q;

  // Capture the faulting address alongside the rest of the context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      badv_q <= '0;
    end else if (take_exc) begin
      badv_q <= exc_badvaddr;
    end
  end
`else
  logic unused_badvaddr;
  assign unused_badvaddr = ^exc_badvaddr;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and write-port / redirect decode
  always_comb begin
    state_d        = state_q;
    cp0_write_en   = 1'b0;
    cp0_write_addr = '0;
    cp0_write_data = '0;
    redirect_o     = 1'b0;
    redirect_pc_o  = '0;
    case (state_q)
      IDLE: begin
        if (buf_valid) begin
          cp0_write_en   = 1'b1;
          cp0_write_addr = buf_addr;
          cp0_write_data = buf_data;
        end else if (wb_cp0_write_en) begin
          cp0_write_en   = 1'b1;
          cp0_write_addr = wb_cp0_write_addr;
          cp0_write_data = wb_cp0_write_data;
        end
        if (exc_req) begin
          state_d = W_EPC;
        end else if (eret_req) begin
          state_d = W_ERET;
        end
      end
      W_EPC: begin
        // A nested exception under EXL must not clobber the original EPC
        cp0_write_en   = ~status_i[STATUS_EXL_BIT];
        cp0_write_addr = cp0_addr(CP0_REG_EPC);
        cp0_write_data = bd_q ? (pc_q - 32'd4) : pc_q;
        state_d        = W_CAUSE;
      end
      W_CAUSE: begin
        cp0_write_en                 = 1'b1;
        cp0_write_addr               = cp0_addr(CP0_REG_CAUSE);
        cp0_write_data               = cause_i;
        cp0_write_data[CAUSE_BD_BIT] = bd_q;
        cp0_write_data[6:2]          = code_q;
        state_d                      = W_STATUS;
      end
      W_STATUS: begin
        cp0_write_en   = 1'b1;
        cp0_write_addr = cp0_addr(CP0_REG_STATUS);
        cp0_write_data = status_i | STATUS_EXL_MASK;
`ifdef CP0_BADVADDR_EN
        if (is_addr_exc(code_q)) begin
          state_d = W_BADV;
        end else begin
          state_d       = IDLE;
          redirect_o    = 1'b1;
          redirect_pc_o = EXC_VECTOR;
        end
`else
        state_d       = IDLE;
        redirect_o    = 1'b1;
        redirect_pc_o = EXC_VECTOR;
`endif
      end
`ifdef CP0_BADVADDR_EN
      W_BADV: begin
        cp0_write_en   = 1'b1;
        cp0_write_addr = cp0_addr(CP0_REG_BADVADDR);
        cp0_write_data = badv_q;
        state_d        = IDLE;
        redirect_o     = 1'b1;
        redirect_pc_o  = EXC_VECTOR;
      end
`endif
      W_ERET: begin
        cp0_write_en   = 1'b1;
        cp0_write_addr = cp0_addr(CP0_REG_STATUS);
        cp0_write_data = status_i & ~STATUS_EXL_MASK;
        state_d        = IDLE;
        redirect_o     = 1'b1;
        redirect_pc_o  = epc_i;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cp0_write_sequencer.sv
// Self-checking bench for cp0_write_sequencer: directed cases plus randomized
// transactions against a cycle-level reference model of the write schedule.
// Honours CP0_BADVADDR_EN the same way the design does.
`timescale 1ns/1ps
module tb_cp0_write_sequencer;
  import cp0_write_sequencer_pkg::*;

  localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;
  localparam logic [7:0] A_BADV   = 8'(8 * 8);
  localparam logic [7:0] A_COMP   = 8'(11 * 8);
  localparam logic [7:0] A_STATUS = 8'(12 * 8);
  localparam logic [7:0] A_CAUSE  = 8'(13 * 8);
  localparam logic [7:0] A_EPC    = 8'(14 * 8);
`ifdef CP0_BADVADDR_EN
  localparam bit BADV_EN = 1'b1;
`else
  localparam bit BADV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_cp0_write_en = 1'b0;
  logic [7:0]  wb_cp0_write_addr = '0;
  logic [31:0] wb_cp0_write_data = '0;
  logic        exc_req = 1'b0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_pc = '0;
  logic        exc_in_delay_slot = 1'b0;
  logic [31:0] exc_badvaddr = '0;
  logic        eret_req = 1'b0;
  logic [31:0] status_i = '0;
  logic [31:0] cause_i = '0;
  logic [31:0] epc_i = '0;
  logic        cp0_write_en;
  logic [7:0]  cp0_write_addr;
  logic [31:0] cp0_write_data;
  logic        busy_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;

  always #5 clk = ~clk;

  cp0_write_sequencer #(.EXC_VECTOR(EXC_VEC)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .wb_cp0_write_en   (wb_cp0_write_en),
    .wb_cp0_write_addr (wb_cp0_write_addr),
    .wb_cp0_write_data (wb_cp0_write_data),
    .exc_req           (exc_req),
    .exc_code          (exc_code),
    .exc_pc            (exc_pc),
    .exc_in_delay_slot (exc_in_delay_slot),
    .exc_badvaddr      (exc_badvaddr),
    .eret_req          (eret_req),
    .status_i          (status_i),
    .cause_i           (cause_i),
    .epc_i             (epc_i),
    .cp0_write_en      (cp0_write_en),
    .cp0_write_addr    (cp0_write_addr),
    .cp0_write_data    (cp0_write_data),
    .busy_o            (busy_o),
    .redirect_o        (redirect_o),
    .redirect_pc_o     (redirect_pc_o)
  );

  // Requests must never arrive while a sequence is running
  assert property (@(posedge clk) disable iff (!rst_n) busy_o |-> !(exc_req || eret_req));

  typedef struct {
    logic        en;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        busy;
    logic        redir;
    logic [31:0] rpc;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the one-deep deferred WB write
  bit          m_pend = 1'b0;
  logic [7:0]  m_paddr = '0;
  logic [31:0] m_pdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_wb(input bit en);
    wb_cp0_write_en   = en;
    wb_cp0_write_addr = 8'($urandom);
    wb_cp0_write_data = $urandom;
  endtask

  // Idle cycle: deferred write goes first, a concurrent WB write is deferred
  task automatic model_idle(output exp_t e);
    e = '{default: '0};
    if (m_pend) begin
      e.en = 1'b1; e.addr = m_paddr; e.data = m_pdata;
      m_pend = wb_cp0_write_en;
      m_paddr = wb_cp0_write_addr; m_pdata = wb_cp0_write_data;
    end else if (wb_cp0_write_en) begin
      e.en = 1'b1; e.addr = wb_cp0_write_addr; e.data = wb_cp0_write_data;
    end
  endtask

  task automatic model_busy();
    if (wb_cp0_write_en) begin
      m_pend = 1'b1; m_paddr = wb_cp0_write_addr; m_pdata = wb_cp0_write_data;
    end
  endtask

  task automatic check_cycle(input string tag, input exp_t e);
    @(negedge clk);
    chk({tag, ".en"}, 32'(cp0_write_en), 32'(e.en));
    if (e.en) begin
      chk({tag, ".addr"}, 32'(cp0_write_addr), 32'(e.addr));
      chk({tag, ".data"}, cp0_write_data, e.data);
    end
    chk({tag, ".busy"}, 32'(busy_o), 32'(e.busy));
    chk({tag, ".redir"}, 32'(redirect_o), 32'(e.redir));
    if (e.redir) chk({tag, ".rpc"}, redirect_pc_o, e.rpc);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle(input string tag, input bit wb);
    exp_t e;
    drive_wb(wb);
    model_idle(e);
    check_cycle(tag, e);
  endtask

  task automatic exc_txn(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                         input logic [31:0] badv, input logic [31:0] st,
                         input bit with_eret, input bit wb0, input bit busy_wb);
    exp_t e;
    bit   adr;
    int   len;
    adr = ((code == 5'd4) || (code == 5'd5)) && BADV_EN;
    len = adr ? 4 : 3;
    status_i = st; cause_i = $urandom; epc_i = $urandom;
    exc_req = 1'b1; exc_code = code; exc_pc = pc; exc_in_delay_slot = bd;
    exc_badvaddr = badv; eret_req = with_eret;
    drive_wb(wb0);
    model_idle(e);
    check_cycle("exc_n", e);
    exc_req = 1'b0; eret_req = 1'b0;
    exc_code = 5'($urandom); exc_pc = $urandom;
    exc_in_delay_slot = 1'($urandom); exc_badvaddr = $urandom;
    for (int k = 1; k <= len; k++) begin
      drive_wb(busy_wb && ($urandom_range(0, 1) == 1));
      if (k > 1) status_i = $urandom;
      cause_i = $urandom;
      e = '{default: '0};
      e.busy = 1'b1;
      case (k)
        1: begin
          e.en = !st[1]; e.addr = A_EPC; e.data = bd ? pc - 32'd4 : pc;
        end
        2: begin
          e.en = 1'b1; e.addr = A_CAUSE;
          e.data = (cause_i & ~32'h8000_007C) | {bd, 31'b0} | {25'b0, code, 2'b0};
        end
        3: begin
          e.en = 1'b1; e.addr = A_STATUS; e.data = status_i | 32'h2;
          e.redir = !adr; e.rpc = EXC_VEC;
        end
        default: begin
          e.en = 1'b1; e.addr = A_BADV; e.data = badv;
          e.redir = 1'b1; e.rpc = EXC_VEC;
        end
      endcase
      model_busy();
      check_cycle($sformatf("exc_k%0d", k), e);
    end
  endtask

  task automatic eret_txn(input logic [31:0] ep, input bit wb0, input bit busy_wb);
    exp_t e;
    status_i = $urandom; epc_i = ep; eret_req = 1'b1;
    drive_wb(wb0);
    model_idle(e);
    check_cycle("eret_n", e);
    eret_req = 1'b0;
    status_i = $urandom;
    drive_wb(busy_wb);
    e = '{default: '0};
    e.en = 1'b1; e.addr = A_STATUS; e.data = status_i & ~32'h2;
    e.busy = 1'b1; e.redir = 1'b1; e.rpc = ep;
    model_busy();
    check_cycle("eret_k1", e);
  endtask

  logic [4:0] codes [8] = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd10, 5'd12, 5'd13, 5'd31};

  initial begin
    exp_t e;
    // Reset state
    @(negedge clk);
    chk("rst.en", 32'(cp0_write_en), 32'd0);
    chk("rst.busy", 32'(busy_o), 32'd0);
    chk("rst.redir", 32'(redirect_o), 32'd0);
    chk("rst.rpc", redirect_pc_o, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // MTC0 Compare pass-through in IDLE
    wb_cp0_write_en = 1'b1; wb_cp0_write_addr = A_COMP; wb_cp0_write_data = 32'h1234;
    e = '{default: '0};
    e.en = 1'b1; e.addr = A_COMP; e.data = 32'h1234;
    check_cycle("mtc0_cmp", e);
    idle_cycle("idle0", 1'b0);

    // Syscall, not in delay slot, EXL clear
    exc_txn(5'd8, 32'h8000_0100, 1'b0, 32'h0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    idle_cycle("post_sys", 1'b0);
    // AdEL in delay slot
    exc_txn(5'd4, 32'h8000_0204, 1'b1, 32'h0000_0003, 32'h0000_0010, 1'b0, 1'b1, 1'b1);
    idle_cycle("post_adel", 1'b0);
    idle_cycle("post_adel2", 1'b0);
    // Nested exception under EXL: EPC write suppressed
    exc_txn(5'd10, 32'h8000_0400, 1'b0, 32'h0, 32'h0000_0003, 1'b1, 1'b0, 1'b0);
    idle_cycle("post_exl", 1'b0);
    // ERET
    eret_txn(32'h8000_0300, 1'b0, 1'b0);
    idle_cycle("post_eret", 1'b0);

    // WB write during W_CAUSE, then reset during W_STATUS
    status_i = 32'h0; exc_req = 1'b1; exc_code = 5'd8; exc_pc = 32'h8000_0500;
    drive_wb(1'b0);
    model_idle(e);
    check_cycle("rtst_n", e);
    exc_req = 1'b0;
    e = '{default: '0};
    e.en = 1'b1; e.addr = A_EPC; e.data = 32'h8000_0500; e.busy = 1'b1;
    check_cycle("rtst_epc", e);
    cause_i = 32'h0; drive_wb(1'b1);
    e.addr = A_CAUSE; e.data = {25'b0, 5'd8, 2'b0};
    check_cycle("rtst_cause", e);
    wb_cp0_write_en = 1'b0;
    rst_n = 1'b0;
    m_pend = 1'b0;
    @(negedge clk);
    chk("rtst.en", 32'(cp0_write_en), 32'd0);
    chk("rtst.addr", 32'(cp0_write_addr), 32'd0);
    chk("rtst.data", cp0_write_data, 32'd0);
    chk("rtst.busy", 32'(busy_o), 32'd0);
    chk("rtst.redir", 32'(redirect_o), 32'd0);
    chk("rtst.rpc", redirect_pc_o, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    idle_cycle("rtst_discard", 1'b0);

    // Randomized mix of idle traffic, exceptions and ERETs
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0: begin
          for (int j = 0; j < int'($urandom_range(1, 3)); j++)
            idle_cycle("rnd_idle", 1'($urandom));
        end
        1: exc_txn(codes[$urandom_range(0, 7)], {$urandom, 2'b00} >> 2 << 2,
                   1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1);
        default: eret_txn($urandom, 1'($urandom), 1'($urandom));
      endcase
      idle_cycle("rnd_gap", 1'($urandom));
    end
    idle_cycle("final0", 1'b0);
    idle_cycle("final1", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
